lfsr_noise_gen: RTL and testbench
=================================

LFSR_NOISE_GEN -- requirements
Module: lfsr_noise_gen

Interface
REQ-001 Parameter WIDTH, default 4: LFSR state width, legal range 3..32.
REQ-002 Parameter TAPS, default 4'b1100: feedback mask of width WIDTH; bit k set means state[k] feeds the XOR.
REQ-003 Parameter SEED_DEFAULT, default 4'b0001: reset and fallback state of width WIDTH; SHALL be non-zero.
REQ-004 Parameter STEPS, default 1: LFSR shifts applied per accepted sample, legal range 1..WIDTH.
REQ-005 clk_i  input  1  sole clock, rising edge.
REQ-006 n_rst_i  input  1  reset, asynchronous and active-low.
REQ-007 enable_i  input  1  run request.
REQ-008 load_i  input  1  seed load strobe.
REQ-009 seed_i  input  WIDTH  seed value captured on load.
REQ-010 ready_i  input  1  consumer accepts sample_o.
REQ-011 sample_o  output  WIDTH  current LFSR state (noise sample).
REQ-012 valid_o  output  1  sample_o is offered.
REQ-013 wrap_o  output  1  one-cycle pulse: sequence returned to the active seed.
REQ-014 seed_err_o  output  1  one-cycle pulse: a zero seed was rejected.

Function
REQ-015 Single shift: fb = XOR-reduce(state & TAPS); next = {state[WIDTH-2:0], fb}, i.e. Fibonacci, shift toward MSB.
REQ-016 Advance: apply REQ-015 STEPS times combinationally within one cycle; registered result appears the cycle after the handshake.
REQ-017 Handshake: a transfer occurs on a rising edge where valid_o=1 and ready_i=1.
REQ-018 State advances only on a transfer; sample_o SHALL remain stable while valid_o=1 and ready_i=0.
REQ-019 FSM has 2 states. IDLE: valid_o=0. RUN: valid_o=1.
REQ-020 IDLE -> RUN when enable_i=1; valid_o goes high the next cycle.
REQ-021 RUN -> IDLE only on a transfer cycle with enable_i=0.
REQ-022 In RUN, enable_i=0 without a transfer holds RUN; an offered sample is never withdrawn.
REQ-023 RUN with enable_i=1 and continuous ready_i=1 delivers one new sample every cycle.
REQ-024 load_i is honoured only in IDLE and is ignored in RUN.
REQ-025 On a load, state and active seed both take seed_i, taking effect the next cycle.
REQ-026 If load_i=1, enable_i=1 and the FSM is in IDLE on the same edge, both take effect: the first sample offered is seed_i.
REQ-027 If seed_i=0 on a load, state and active seed take SEED_DEFAULT and seed_err_o pulses high for 1 cycle.
REQ-028 wrap_o is registered and high for exactly the cycle in which post-transfer state equals the active seed.
REQ-029 With STEPS>1, wrap is detected only on post-advance states; intermediate shifts are not checked.
REQ-030 State SHALL never become all-zero; zero is unreachable through REQ-015 and REQ-027.

Reset
REQ-031 While n_rst_i=0, asynchronously: state=SEED_DEFAULT, active seed=SEED_DEFAULT, FSM=IDLE, valid_o=0, wrap_o=0, seed_err_o=0, sample_o=SEED_DEFAULT.
REQ-032 Reset asserted mid-RUN aborts immediately; after release, the first sample offered is SEED_DEFAULT.
REQ-033 Release of reset is synchronous to clk_i via normal flop behaviour; no extra synchroniser is required inside the block.

Verification
REQ-034 Defaults, enable_i=1, ready_i=1 held -> sample_o sequence 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1 (hex); wrap_o pulses with the second 1; period 15.
REQ-035 Backpressure: ready_i low 3 cycles mid-run -> sample_o and valid_o frozen; sequence resumes unchanged after ready_i returns high.
REQ-036 IDLE, load_i=1, seed_i=4'hB, then enable -> first samples B,7,F; wrap_o after 15 transfers, coincident with B.
REQ-037 IDLE, load_i=1, seed_i=0 -> seed_err_o single-cycle pulse; first sample 1.
REQ-038 RUN with ready_i=0: enable_i=0, and load_i=1 with seed_i=4'h6 -> valid_o stays 1, load ignored; IDLE only after next accept.
REQ-039 WIDTH=8, TAPS=8'hB8, STEPS=8, enable_i=1 and ready_i=1 -> 255 distinct non-zero states before wrap; mid-run reset -> 1 restarts.

Source files
------------

// File: rtl/lfsr_noise_gen.sv
// Fibonacci LFSR noise source with a valid/ready sample port, runtime seed load
// and wrap / rejected-seed pulses.
module lfsr_noise_gen #(
  parameter int              WIDTH        = 4,
  parameter logic [WIDTH-1:0] TAPS         = 4'b1100,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 4'b0001,
  parameter int              STEPS        = 1
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             enable_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sample_o,
  output logic             valid_o,
  output logic             wrap_o,
  output logic             seed_err_o
);

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] seed_q;
  logic [WIDTH-1:0] next_state;
  logic             wrap_q;
  logic             seed_err_q;
  logic             do_load;
  logic             do_xfer;

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $fatal(1, "lfsr_noise_gen: WIDTH must be 3..32");
  end
  if (STEPS < 1 || STEPS > WIDTH) begin : g_bad_steps
    $fatal(1, "lfsr_noise_gen: STEPS must be 1..WIDTH");
  end
  if (SEED_DEFAULT == '0) begin : g_bad_seed
    $fatal(1, "lfsr_noise_gen: SEED_DEFAULT must be non-zero");
  end

  // All STEPS shifts happen in one cycle; only the final state is ever visible.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int i = 0; i < STEPS; i++) begin
      t = {t[WIDTH-2:0], ^(t & TAPS)};
    end
    return t;
  endfunction

  assign next_state = advance(state_q);

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // A sample once offered stays offered until it is taken, so RUN only exits on a transfer.
  always_comb begin
    fsm_d   = fsm_q;
    do_load = 1'b0;
    do_xfer = 1'b0;
    case (fsm_q)
      IDLE: begin
        do_load = load_i;
        if (enable_i) fsm_d = RUN;
      end
      RUN: begin
        do_xfer = ready_i;
        if (ready_i && !enable_i) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state_q    <= SEED_DEFAULT;
      seed_q     <= SEED_DEFAULT;
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
    end else begin
      wrap_q     <= 1'b0;
      seed_err_q <= 1'b0;
      if (do_load) begin
        // A zero seed would lock the register at zero, so fall back to the default.
        if (seed_i == '0) begin
          state_q    <= SEED_DEFAULT;
          seed_q     <= SEED_DEFAULT;
          seed_err_q <= 1'b1;
        end else begin
          state_q <= seed_i;
          seed_q  <= seed_i;
        end
      end else if (do_xfer) begin
        state_q <= next_state;
        wrap_q  <= (next_state == seed_q);
      end
    end
  end

  assign sample_o   = state_q;
  assign valid_o    = (fsm_q == RUN);
  assign wrap_o     = wrap_q;
  assign seed_err_o = seed_err_q;

endmodule

// File: tb/tb_lfsr_noise_gen.sv
// Bench for lfsr_noise_gen: default 4-bit instance plus an 8-bit, 8-step instance,
// checked every cycle against a sequence-level model and pinned by literal values.
module tb_lfsr_noise_gen;

  typedef struct packed {
    logic        run;
    logic [31:0] state;
    logic [31:0] seed;
    logic        wrap;
    logic        err;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ld = 1'b0;
  logic [3:0] seed = 4'h0;
  logic       rdy = 1'b0;
  logic [3:0] sample4;
  logic       valid4, wrap4, err4;

  logic       rst8_n = 1'b0;
  logic       en8 = 1'b0;
  logic       ld8 = 1'b0;
  logic [7:0] seed8 = 8'h00;
  logic       rdy8 = 1'b0;
  logic [7:0] sample8;
  logic       valid8, wrap8, err8;

  logic       chk_on = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;
  mstate_t    m4, m8;
  logic [255:0] seen;

  always #5 clk = ~clk;

  lfsr_noise_gen dut4 (
    .clk_i(clk), .n_rst_i(rst_n), .enable_i(en), .load_i(ld), .seed_i(seed),
    .ready_i(rdy), .sample_o(sample4), .valid_o(valid4), .wrap_o(wrap4),
    .seed_err_o(err4)
  );

  lfsr_noise_gen #(.WIDTH(8), .TAPS(8'hB8), .SEED_DEFAULT(8'h01), .STEPS(8)) dut8 (
    .clk_i(clk), .n_rst_i(rst8_n), .enable_i(en8), .load_i(ld8), .seed_i(seed8),
    .ready_i(rdy8), .sample_o(sample8), .valid_o(valid8), .wrap_o(wrap8),
    .seed_err_o(err8)
  );

  // 4-bit successor comes straight from the published maximal-length sequence.
  function automatic logic [31:0] next_sample(input logic [31:0] s, input int w);
    logic [31:0] t;
    if (w == 4) begin
      case (s)
        32'h1: t = 32'h2;  32'h2: t = 32'h4;  32'h4: t = 32'h9;  32'h9: t = 32'h3;
        32'h3: t = 32'h6;  32'h6: t = 32'hD;  32'hD: t = 32'hA;  32'hA: t = 32'h5;
        32'h5: t = 32'hB;  32'hB: t = 32'h7;  32'h7: t = 32'hF;  32'hF: t = 32'hE;
        32'hE: t = 32'hC;  32'hC: t = 32'h8;  32'h8: t = 32'h1;
        default: t = 32'h0;
      endcase
    end else begin
      t = s;
      for (int k = 0; k < 8; k++) begin
        t = ((t << 1) & 32'hFF) | ($countones(t & 32'hB8) % 2);
      end
    end
    return t;
  endfunction

  function automatic mstate_t model_next(input mstate_t cur, input logic e, input logic l,
                                         input logic [31:0] sd, input logic r, input int w);
    mstate_t nxt;
    nxt      = cur;
    nxt.wrap = 1'b0;
    nxt.err  = 1'b0;
    if (!cur.run) begin
      if (l) begin
        nxt.state = (sd == 0) ? 32'h1 : sd;
        nxt.seed  = nxt.state;
        nxt.err   = (sd == 0);
      end
      if (e) nxt.run = 1'b1;
    end else if (r) begin
      nxt.state = next_sample(cur.state, w);
      nxt.wrap  = (nxt.state == cur.seed);
      if (!e) nxt.run = 1'b0;
    end
    return nxt;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m4 <= '{run: 1'b0, state: 32'h1, seed: 32'h1, wrap: 1'b0, err: 1'b0};
    else        m4 <= model_next(m4, en, ld, {28'h0, seed}, rdy, 4);
  end

  always @(posedge clk or negedge rst8_n) begin
    if (!rst8_n) m8 <= '{run: 1'b0, state: 32'h1, seed: 32'h1, wrap: 1'b0, err: 1'b0};
    else         m8 <= model_next(m8, en8, ld8, {24'h0, seed8}, rdy8, 8);
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check_output("sample4", {28'h0, sample4}, m4.state);
      check_output("valid4", {31'h0, valid4}, {31'h0, m4.run});
      check_output("wrap4", {31'h0, wrap4}, {31'h0, m4.wrap});
      check_output("seed_err4", {31'h0, err4}, {31'h0, m4.err});
      check_output("sample8", {24'h0, sample8}, m8.state);
      check_output("valid8", {31'h0, valid8}, {31'h0, m8.run});
      check_output("wrap8", {31'h0, wrap8}, {31'h0, m8.wrap});
      check_output("seed_err8", {31'h0, err8}, {31'h0, m8.err});
    end
  end

  initial begin
    apply_stimulus(2);
    chk_on = 1'b1;
    check_output("rst_sample", {28'h0, sample4}, 32'h1);
    check_output("rst_valid", {31'h0, valid4}, 32'h0);
    rst_n = 1'b1;
    rst8_n = 1'b1;
    apply_stimulus(1);
    check_output("idle_valid", {31'h0, valid4}, 32'h0);

    // Free run from reset: 1,2,4,9,... back to 1 after 15 transfers
    en = 1'b1;
    rdy = 1'b1;
    apply_stimulus(1);
    check_output("first_sample", {28'h0, sample4}, 32'h1);
    check_output("first_valid", {31'h0, valid4}, 32'h1);
    apply_stimulus(3);
    check_output("third_xfer", {28'h0, sample4}, 32'h9);
    apply_stimulus(12);
    check_output("wrap_sample", {28'h0, sample4}, 32'h1);
    check_output("wrap_pulse", {31'h0, wrap4}, 32'h1);

    // Backpressure freezes the offered sample
    apply_stimulus(2);
    rdy = 1'b0;
    apply_stimulus(3);
    check_output("bp_sample", {28'h0, sample4}, 32'h4);
    check_output("bp_valid", {31'h0, valid4}, 32'h1);
    rdy = 1'b1;
    apply_stimulus(1);
    check_output("bp_resume", {28'h0, sample4}, 32'h9);

    en = 1'b0;
    apply_stimulus(1);
    check_output("stop_valid", {31'h0, valid4}, 32'h0);

    // Load B together with enable
    ld = 1'b1;
    seed = 4'hB;
    en = 1'b1;
    apply_stimulus(1);
    ld = 1'b0;
    check_output("load_first", {28'h0, sample4}, 32'hB);
    apply_stimulus(1);
    check_output("load_second", {28'h0, sample4}, 32'h7);
    apply_stimulus(1);
    check_output("load_third", {28'h0, sample4}, 32'hF);
    apply_stimulus(12);
    check_output("no_early_wrap", {31'h0, wrap4}, 32'h0);
    apply_stimulus(1);
    check_output("seed_wrap_sample", {28'h0, sample4}, 32'hB);
    check_output("seed_wrap_pulse", {31'h0, wrap4}, 32'h1);

    // Disable and load while stalled in RUN: nothing changes until accepted
    rdy = 1'b0;
    en = 1'b0;
    ld = 1'b1;
    seed = 4'h6;
    apply_stimulus(2);
    check_output("stall_valid", {31'h0, valid4}, 32'h1);
    check_output("stall_sample", {28'h0, sample4}, 32'hB);
    rdy = 1'b1;
    ld = 1'b0;
    apply_stimulus(1);
    check_output("exit_valid", {31'h0, valid4}, 32'h0);
    check_output("exit_sample", {28'h0, sample4}, 32'h7);

    // Zero seed is rejected
    ld = 1'b1;
    seed = 4'h0;
    apply_stimulus(1);
    check_output("zero_err", {31'h0, err4}, 32'h1);
    check_output("zero_sample", {28'h0, sample4}, 32'h1);
    ld = 1'b0;
    apply_stimulus(1);
    check_output("zero_err_clear", {31'h0, err4}, 32'h0);
    en = 1'b1;
    apply_stimulus(1);
    check_output("zero_first", {28'h0, sample4}, 32'h1);
    apply_stimulus(3);

    // Asynchronous reset mid-run
    rst_n = 1'b0;
    #2;
    check_output("async_valid", {31'h0, valid4}, 32'h0);
    check_output("async_sample", {28'h0, sample4}, 32'h1);
    apply_stimulus(1);
    rst_n = 1'b1;
    apply_stimulus(1);
    check_output("post_rst_first", {28'h0, sample4}, 32'h1);
    en = 1'b0;
    apply_stimulus(1);

    // 8-bit, 8 steps per sample: full 255-state cycle
    seen = '0;
    seen[1] = 1'b1;
    en8 = 1'b1;
    rdy8 = 1'b1;
    apply_stimulus(1);
    check_output("w8_first", {24'h0, sample8}, 32'h1);
    for (int i = 1; i <= 255; i++) begin
      apply_stimulus(1);
      if (i < 255) begin
        check_output("w8_nonzero", {31'h0, (sample8 == 8'h00)}, 32'h0);
        check_output("w8_distinct", {31'h0, seen[sample8]}, 32'h0);
        seen[sample8] = 1'b1;
      end else begin
        check_output("w8_wrap_sample", {24'h0, sample8}, 32'h1);
        check_output("w8_wrap_pulse", {31'h0, wrap8}, 32'h1);
      end
    end
    apply_stimulus(5);
    rst8_n = 1'b0;
    #2;
    check_output("w8_rst_sample", {24'h0, sample8}, 32'h1);
    check_output("w8_rst_valid", {31'h0, valid8}, 32'h0);
    apply_stimulus(1);
    rst8_n = 1'b1;
    apply_stimulus(1);
    check_output("w8_restart", {24'h0, sample8}, 32'h1);
    check_output("w8_restart_valid", {31'h0, valid8}, 32'h1);
    apply_stimulus(2);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
